// File: rtl/rider_pkg.sv
// Shared widths, default thresholds/timer lengths and the flag bundle for the
// rider load monitor.
package rider_pkg;

  localparam int LD_W  = 12;
  localparam int SUM_W = 13;

  localparam logic [LD_W-1:0] MIN_RIDER_WEIGHT_DEF  = 12'h200;
  localparam logic [LD_W-1:0] HYSTERESIS_DEF        = 12'h040;
  localparam int unsigned     TMR_CYCLES_DEF        = 65_000_000;
  localparam int unsigned     STALE_CYCLES_DEF      = 1_000_000;

  // Short timer lengths so simulations finish quickly.
  localparam int unsigned     FAST_SIM_TMR_CYCLES   = 16;
  localparam int unsigned     FAST_SIM_STALE_CYCLES = 8;

  typedef struct packed {
    logic sum_gt_min;
    logic sum_lt_min;
    logic diff_gt_eigth;
    logic diff_gt_15_16;
  } rider_flags_t;

  // Qualifier set that makes the steering FSM treat the platform as empty.
  localparam rider_flags_t RIDER_OFF_FLAGS = '{
    sum_gt_min:    1'b0,
    sum_lt_min:    1'b1,
    diff_gt_eigth: 1'b0,
    diff_gt_15_16: 1'b0
  };

  function automatic logic [LD_W-1:0] abs_diff(input logic [LD_W-1:0] a,
                                               input logic [LD_W-1:0] b);
    logic signed [SUM_W-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) begin
      d = -d;
    end
    return d[LD_W-1:0];
  endfunction

endpackage

// File: rtl/rider_load_monitor_sat_timer.sv
// Saturating up-counter with synchronous clear; full is high while the count
// sits at MAX.
module sat_timer #(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic full
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over increment; the count parks at MAX until cleared.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != MAX_C) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full = (count_q == MAX_C);

endmodule

// File: rtl/rider_load_monitor.sv
// Load-cell capture, sum/difference arithmetic, hysteretic rider flags, plus
// the settle timer and stale-data watchdog feeding the steering-enable FSM.
module rider_load_monitor
  import rider_pkg::*;
#(
  parameter logic [LD_W-1:0] MIN_RIDER_WEIGHT = MIN_RIDER_WEIGHT_DEF,
  parameter logic [LD_W-1:0] HYSTERESIS       = HYSTERESIS_DEF,
  parameter int unsigned     TMR_CYCLES       = TMR_CYCLES_DEF,
  parameter int unsigned     STALE_CYCLES     = STALE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  input  logic            clr_tmr,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_eigth,
  output logic            diff_gt_15_16,
  output logic            tmr_full,
  output logic            data_stale
);

  localparam logic [SUM_W-1:0] GT_THRESH = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [SUM_W-1:0] LT_THRESH = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};

  logic [LD_W-1:0] ld_in  [2];
  logic [LD_W-1:0] ld_cap [2];

  assign ld_in[0] = lft_ld;
  assign ld_in[1] = rght_ld;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cap
    logic [LD_W-1:0] cap_q;
    logic [LD_W-1:0] cap_d;

    always_comb begin
      cap_d = cap_q;
      if (ld_vld) begin
        cap_d = ld_in[gi];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cap_q <= '0;
      end else begin
        cap_q <= cap_d;
      end
    end

    assign ld_cap[gi] = cap_q;
  end

  // Marks the one cycle in which the captured pair is fresh.
  logic cap_vld_q;
  logic cap_vld_d;

  assign cap_vld_d = ld_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= cap_vld_d;
    end
  end

  logic [SUM_W-1:0] sum;
  logic [LD_W-1:0]  diff;
  rider_flags_t     calc_flags;

  always_comb begin
    sum  = {1'b0, ld_cap[0]} + {1'b0, ld_cap[1]};
    diff = abs_diff(ld_cap[0], ld_cap[1]);
    calc_flags.sum_gt_min    = (sum > GT_THRESH);
    calc_flags.sum_lt_min    = (sum < LT_THRESH);
    calc_flags.diff_gt_eigth = ({1'b0, diff} > (sum >> 3));
    calc_flags.diff_gt_15_16 = ({1'b0, diff} > (sum - (sum >> 4)));
  end

  logic stale;

  sat_timer #(.MAX(STALE_CYCLES)) u_stale_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ld_vld),
    .full  (stale)
  );

  sat_timer #(.MAX(TMR_CYCLES)) u_settle_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clr_tmr),
    .full  (tmr_full)
  );

  rider_flags_t flags_q;
  rider_flags_t flags_d;

  // While stale the register is loaded with the rider-off set, so the cycle
  // after a fresh strobe clears stale still shows rider-off, not old data.
  always_comb begin
    flags_d = flags_q;
    if (stale) begin
      flags_d = RIDER_OFF_FLAGS;
    end else if (cap_vld_q) begin
      flags_d = calc_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RIDER_OFF_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

  rider_flags_t flags_out;

  assign flags_out     = stale ? RIDER_OFF_FLAGS : flags_q;
  assign sum_gt_min    = flags_out.sum_gt_min;
  assign sum_lt_min    = flags_out.sum_lt_min;
  assign diff_gt_eigth = flags_out.diff_gt_eigth;
  assign diff_gt_15_16 = flags_out.diff_gt_15_16;
  assign data_stale    = stale;

endmodule

// File: tb/tb_rider_load_monitor.sv
// Scoreboard bench for rider_load_monitor: stimulus queues expected output
// vectors tagged with the cycle they are due; a negedge monitor checks them.
module tb_rider_load_monitor;
  import rider_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic        ld_vld = 1'b0;
  logic        clr_tmr = 1'b0;
  logic        sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16;
  logic        tmr_full, data_stale;

  always #5 clk = ~clk;

  rider_load_monitor #(
    .TMR_CYCLES   (FAST_SIM_TMR_CYCLES),
    .STALE_CYCLES (FAST_SIM_STALE_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lft_ld        (lft_ld),
    .rght_ld       (rght_ld),
    .ld_vld        (ld_vld),
    .clr_tmr       (clr_tmr),
    .sum_gt_min    (sum_gt_min),
    .sum_lt_min    (sum_lt_min),
    .diff_gt_eigth (diff_gt_eigth),
    .diff_gt_15_16 (diff_gt_15_16),
    .tmr_full      (tmr_full),
    .data_stale    (data_stale)
  );

  // Vector bit order: {sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, tmr_full, data_stale}
  localparam logic [5:0] M_ALL   = 6'b111111;
  localparam logic [5:0] M_NOTMR = 6'b111101;
  localparam logic [5:0] M_TMR   = 6'b000010;

  typedef struct {
    int         due;
    string      name;
    logic [5:0] exp;
    logic [5:0] mask;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] obs;
  assign obs = {sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16, tmr_full, data_stale};

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        n_vec++;
        if ((obs & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %b required %b (mask %b)",
                   sb[i].name, cyc, obs, sb[i].exp, sb[i].mask);
        end else begin
          $display("ok   %s @cyc %0d: %b", sb[i].name, cyc, obs & sb[i].mask);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s: never checked, due cyc %0d", sb[i].name, sb[i].due);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input int due, input string name, input logic [3:0] fl,
                           input logic tmr, input logic st, input logic [5:0] mask);
    chk_t c;
    c.due  = due;
    c.name = name;
    c.exp  = {fl, tmr, st};
    c.mask = mask;
    sb.push_back(c);
  endtask

  // Strobe one sample this cycle; flags and data_stale=0 are due two cycles on.
  task automatic strobe(input logic [11:0] l, input logic [11:0] r,
                        input logic [3:0] fl, input string name);
    lft_ld  = l;
    rght_ld = r;
    ld_vld  = 1'b1;
    expect_at(cyc + 2, name, fl, 1'b0, 1'b0, M_NOTMR);
    tick();
    ld_vld = 1'b0;
  endtask

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    logic [3:0]  fl;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n, m, k, j, h, rr;

    vecs[0] = '{12'h180, 12'h180, 4'b1000, "balanced_heavy"};
    vecs[1] = '{12'h100, 12'h100, 4'b0000, "band_sum200"};
    vecs[2] = '{12'h0DF, 12'h0E0, 4'b0100, "below_sum1BF"};
    vecs[3] = '{12'h121, 12'h120, 4'b1000, "above_sum241"};
    vecs[4] = '{12'h120, 12'h120, 4'b0000, "edge_sum240"};
    vecs[5] = '{12'h300, 12'h100, 4'b1010, "imbal_eighth"};
    vecs[6] = '{12'h3F0, 12'h000, 4'b1011, "imbal_both"};
    vecs[7] = '{12'h1C0, 12'h000, 4'b0011, "edge_sum1C0"};
    vecs[8] = '{12'h240, 12'h1C0, 4'b1000, "diff_eq_eighth"};
    vecs[9] = '{12'h100, 12'h300, 4'b1010, "imbal_right"};

    tick();
    tick();
    expect_at(cyc, "reset_hold", 4'b0100, 1'b0, 1'b0, M_ALL);
    tick();
    rst_n = 1'b1;

    // Back-to-back strobes through the arithmetic table.
    for (int v = 0; v < 10; v++) begin
      strobe(vecs[v].l, vecs[v].r, vecs[v].fl, vecs[v].name);
    end

    // Stale watchdog after a heavy sample.
    n = cyc;
    strobe(12'h180, 12'h180, 4'b1000, "stale_pre");
    expect_at(n + 8, "stale_not_yet", 4'b1000, 1'b0, 1'b0, M_NOTMR);
    expect_at(n + 9, "stale_set", 4'b0100, 1'b0, 1'b1, M_NOTMR);
    wait_until(n + 12);

    // Fresh strobe after stale: stale drops next cycle, flags one later.
    m = cyc;
    expect_at(m, "stale_held", 4'b0100, 1'b0, 1'b1, M_NOTMR);
    expect_at(m + 1, "stale_clear_off", 4'b0100, 1'b0, 1'b0, M_NOTMR);
    strobe(12'h3F0, 12'h000, 4'b1011, "stale_recover");

    // Strobe on the clock the watchdog would otherwise saturate.
    wait_until(m + 8);
    strobe(12'h180, 12'h180, 4'b1000, "strobe_8th");
    expect_at(m + 9, "no_stale_8th", 4'b0000, 1'b0, 1'b0, 6'b000001);
    expect_at(m + 16, "stale_not_yet2", 4'b1000, 1'b0, 1'b0, M_NOTMR);
    expect_at(m + 17, "stale_set2", 4'b0100, 1'b0, 1'b1, M_NOTMR);
    wait_until(m + 18);

    // Settle timer: single clear pulse.
    k = cyc;
    clr_tmr = 1'b1;
    tick();
    clr_tmr = 1'b0;
    expect_at(k + 1, "tmr_cleared", 4'b0000, 1'b0, 1'b0, M_TMR);
    expect_at(k + 16, "tmr_not_yet", 4'b0000, 1'b0, 1'b0, M_TMR);
    expect_at(k + 17, "tmr_full", 4'b0000, 1'b1, 1'b0, M_TMR);
    expect_at(k + 25, "tmr_hold", 4'b0000, 1'b1, 1'b0, M_TMR);
    wait_until(k + 26);

    // Clear while full.
    j = cyc;
    expect_at(j, "tmr_full_pre", 4'b0000, 1'b1, 1'b0, M_TMR);
    expect_at(j + 1, "tmr_clr_full", 4'b0000, 1'b0, 1'b0, M_TMR);
    clr_tmr = 1'b1;
    tick();
    clr_tmr = 1'b0;

    // Clear held continuously for 40 cycles.
    h = cyc;
    clr_tmr = 1'b1;
    expect_at(h + 17, "tmr_held_a", 4'b0000, 1'b0, 1'b0, M_TMR);
    expect_at(h + 18, "tmr_held_b", 4'b0000, 1'b0, 1'b0, M_TMR);
    expect_at(h + 39, "tmr_held_c", 4'b0000, 1'b0, 1'b0, M_TMR);
    expect_at(h + 55, "tmr_rel_not", 4'b0000, 1'b0, 1'b0, M_TMR);
    expect_at(h + 56, "tmr_rel_full", 4'b0000, 1'b1, 1'b0, M_TMR);
    wait_until(h + 40);
    clr_tmr = 1'b0;

    // Asynchronous reset mid-operation with heavy flags and a full timer.
    rr = h + 60;
    wait_until(rr - 3);
    strobe(12'h180, 12'h180, 4'b1000, "pre_reset_flags");
    expect_at(rr - 1, "pre_reset_tmr", 4'b0000, 1'b1, 1'b0, M_TMR);
    wait_until(rr);
    rst_n = 1'b0;
    expect_at(rr, "async_reset", 4'b0100, 1'b0, 1'b0, M_ALL);
    tick();
    tick();
    rst_n = 1'b1;
    expect_at(rr + 9, "post_rst_fresh", 4'b0100, 1'b0, 1'b0, M_NOTMR);
    expect_at(rr + 10, "post_rst_stale", 4'b0100, 1'b0, 1'b1, M_NOTMR);
    expect_at(rr + 17, "post_rst_tmr0", 4'b0000, 1'b0, 1'b0, M_TMR);
    expect_at(rr + 18, "post_rst_tmr1", 4'b0000, 1'b1, 1'b0, M_TMR);
    wait_until(rr + 21);

    while (sb.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: left in scoreboard, due cyc %0d", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
